sram_ctrl_banked: RTL and testbench
===================================

Name: sram_ctrl_banked

Overview:
Parametrised multi-bank successor to the single-bank SRAM controller. It fronts NumBanks single-port SRAM macros behind one host request/grant interface. It runs a hardware pseudo-random initialisation of all banks in parallel, and enforces an escalation lock that scraps access permanently until reset. It sits between the TL-UL adapter and the bank macros inside the SRAM subsystem.

Parameters:
NumBanks, 2, number of SRAM banks; power of 2, >=1
Depth, 1024, words per bank; power of 2, >=2
DataWidth, 39, word width (32 data + 7 integrity); must be >= LfsrWidth
LfsrWidth, 32, width of init-pattern LFSR
LfsrSeed, 32'hACE1_1234, LFSR reset/restart value; must be nonzero
LfsrPoly, 32'h8020_0003, Galois feedback taps

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
init_req_i  in  1  pulse/level: start (re)initialisation
escalate_i  in  1  escalation; sticky lock
init_done_o  out  1  all banks initialised, host access open
locked_o  out  1  escalation lock active
req_i  in  1  host request
we_i  in  1  host write enable
addr_i  in  AW=$clog2(NumBanks*Depth)  word address; MSBs = bank, LSBs = word
wdata_i  in  DataWidth  host write data
gnt_o  out  1  request accepted this cycle
rvalid_o  out  1  read data valid
rdata_o  out  DataWidth  read data
rerror_o  out  1  read rejected (lock)
mem_req_o  out  NumBanks  per-bank request
mem_we_o  out  1  shared write enable
mem_addr_o  out  $clog2(Depth)  shared word address
mem_wdata_o  out  DataWidth  shared write data
mem_rdata_i  in  NumBanks*DataWidth  bank read data, 1-cycle latency
rd_cnt_o  out  32  read count (see Optional Feature)
wr_cnt_o  out  32  write count (see Optional Feature)

Behaviour:
- Clock, reset and interface: one clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE; init_done_o, locked_o, gnt_o, rvalid_o, rerror_o = 0; rdata_o=0; mem_req_o=0; LFSR=LfsrSeed; word counter=0.
- FSM states: IDLE, INIT, READY, LOCK.
- IDLE:
  - init_req_i -> INIT.
  - Host req gets gnt_o=0.
- INIT:
  - Each cycle: mem_req_o=all ones, mem_we_o=1, mem_addr_o=counter, mem_wdata_o=LFSR zero-extended to DataWidth.
  - Then counter+1 and LFSR steps.
  - After writing address Depth-1 -> READY next cycle; counter wraps to 0.
  - Duration is exactly Depth cycles.
  - init_req_i is ignored while in INIT.
- READY:
  - init_done_o=1. gnt_o=req_i, combinational, same cycle.
  - Granted access drives the mem_req_o bit selected by addr_i MSBs; mem_addr_o=addr LSBs; mem_we_o=we_i; mem_wdata_o=wdata_i.
  - Read: rvalid_o=1 exactly one cycle after grant. rdata_o = slice of mem_rdata_i at the bank index registered at grant.
  - Back-to-back reads sustain 1/cycle.
  - Writes produce no rvalid.
- init_req_i in READY:
  - Same cycle gets no grant.
  - LFSR reset to LfsrSeed, counter=0, init_done_o drops next cycle, -> INIT.
  - A read granted the previous cycle still returns its rvalid.
- LOCK (from any state when escalate_i=1, priority over everything):
  - locked_o=1, init_done_o=0, mem_req_o=0.
  - Host requests are granted (no bus hang). Reads return rvalid_o=1, rerror_o=1, rdata_o=0 one cycle later. Writes are dropped.
  - Exit only via rst_i.
  - escalate_i and req_i in the same cycle: treated as LOCK; the request gets LOCK semantics.
  - An in-flight read from the previous cycle returns its real data.
- rst_i mid-INIT: returns to IDLE; partial contents are not guaranteed; the next INIT restarts from LfsrSeed.
- LFSR step (Galois): lsb=l[0]; l = l>>1; if lsb, l ^= LfsrPoly.

Optional Feature:
SRAM_CTRL_BANKED_PERF_EN:
- Defined: rd_cnt_o and wr_cnt_o count granted host reads and writes in READY. Both are 32-bit, saturate at 32'hFFFF_FFFF, and clear on rst_i and on entry to INIT.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset, then init_req_i pulse with Depth=4, NumBanks=2:
  - mem_req_o=2'b11 for exactly 4 cycles.
  - Word 0 data = 39'h00_ACE1_1234; words 1-3 = successive LFSR steps.
  - init_done_o=1 on cycle 5.
- READY, write 39'h12_3456_789A to addr 5 (bank1, word1), then read addr 5:
  - Write drives mem_req_o=2'b10, mem_addr_o=1.
  - Read gives rvalid_o the cycle after grant, with rdata_o = bank1 model data 39'h12_3456_789A.
- Back-to-back reads addr 0, 4, 1 (alternating banks): three consecutive rvalid_o cycles, each with the correct bank slice.
- escalate_i=1 together with a read req:
  - locked_o=1 next cycle, mem_req_o stays 0.
  - Next cycle rvalid_o=1, rerror_o=1, rdata_o=0.
  - Lock persists after escalate_i drops, until rst_i.
- init_req_i during READY, and again mid-INIT:
  - Re-init restarts from LfsrSeed.
  - The second request is ignored: exactly Depth write cycles total.
  - rst_i asserted mid-INIT returns to IDLE with init_done_o=0.
- PERF_EN build: 3 reads + 2 writes gives rd_cnt_o=3, wr_cnt_o=2; both clear to 0 on re-init.

Source files
------------

// File: rtl/sram_ctrl_banked.sv
// Multi-bank SRAM controller: parallel LFSR initialisation of all banks, host grant path, sticky escalation lock.
// Define SRAM_CTRL_BANKED_PERF_EN to add saturating read/write counters on rd_cnt_o/wr_cnt_o.
module sram_ctrl_banked #(
  parameter int NumBanks  = 2,
  parameter int Depth     = 1024,
  parameter int DataWidth = 39,
  parameter int LfsrWidth = 32,
  parameter logic [LfsrWidth-1:0] LfsrSeed = 32'hACE1_1234,
  parameter logic [LfsrWidth-1:0] LfsrPoly = 32'h8020_0003,
  localparam int AW  = $clog2(NumBanks*Depth),
  localparam int WAW = $clog2(Depth),
  localparam int BW  = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          init_req_i,
  input  logic                          escalate_i,
  output logic                          init_done_o,
  output logic                          locked_o,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [AW-1:0]                 addr_i,
  input  logic [DataWidth-1:0]          wdata_i,
  output logic                          gnt_o,
  output logic                          rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          rerror_o,
  output logic [NumBanks-1:0]           mem_req_o,
  output logic                          mem_we_o,
  output logic [WAW-1:0]                mem_addr_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  input  logic [NumBanks*DataWidth-1:0] mem_rdata_i,
  output logic [31:0]                   rd_cnt_o,
  output logic [31:0]                   wr_cnt_o
);

  typedef enum logic [1:0] {IDLE, INIT, READY, LOCK} state_t;

  state_t               r_state, w_state_next;
  logic [LfsrWidth-1:0] r_lfsr;
  logic [WAW-1:0]       r_cnt;
  logic                 r_rd_valid, r_rd_err;
  logic [BW-1:0]        r_rd_bank;

  logic                 w_host_go, w_rd_fire, w_err_fire, w_init_start, w_init_step;
  logic [BW-1:0]        w_bank;
  logic [NumBanks-1:0]  w_bank_sel;

  function automatic logic [LfsrWidth-1:0] lfsrStep(input logic [LfsrWidth-1:0] l);
    return (l >> 1) ^ (l[0] ? LfsrPoly : '0);
  endfunction

  assign w_bank     = BW'(addr_i >> WAW);
  assign w_bank_sel = NumBanks'(1) << w_bank;
  assign w_rd_fire  = w_host_go & ~we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_lfsr     <= LfsrSeed;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_bank  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rd_valid <= w_rd_fire;
      r_rd_err   <= w_err_fire;
      if (w_rd_fire) r_rd_bank <= w_bank;
      if (w_init_start) begin
        r_lfsr <= LfsrSeed;
        r_cnt  <= '0;
      end else if (w_init_step) begin
        r_lfsr <= lfsrStep(r_lfsr);
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // Escalation overrides every state: requests are still granted so the bus never hangs,
  // but no bank is touched and reads come back flagged as errors.
  always_comb begin
    w_state_next = r_state;
    w_host_go    = 1'b0;
    w_err_fire   = 1'b0;
    w_init_start = 1'b0;
    w_init_step  = 1'b0;
    gnt_o        = 1'b0;
    mem_req_o    = '0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (escalate_i || r_state == LOCK) begin
      w_state_next = LOCK;
      gnt_o        = req_i;
      w_err_fire   = req_i & ~we_i;
    end else begin
      case (r_state)
        IDLE: begin
          if (init_req_i) begin
            w_state_next = INIT;
            w_init_start = 1'b1;
          end
        end
        INIT: begin
          mem_req_o   = '1;
          mem_we_o    = 1'b1;
          mem_addr_o  = r_cnt;
          mem_wdata_o = DataWidth'(r_lfsr);
          w_init_step = 1'b1;
          if (r_cnt == WAW'(Depth-1)) w_state_next = READY;
        end
        READY: begin
          if (init_req_i) begin
            w_state_next = INIT;
            w_init_start = 1'b1;
          end else if (req_i) begin
            w_host_go   = 1'b1;
            gnt_o       = 1'b1;
            mem_req_o   = w_bank_sel;
            mem_we_o    = we_i;
            mem_addr_o  = addr_i[WAW-1:0];
            mem_wdata_o = wdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign init_done_o = (r_state == READY);
  assign locked_o    = (r_state == LOCK);
  assign rvalid_o    = r_rd_valid | r_rd_err;
  assign rerror_o    = r_rd_err;
  assign rdata_o     = r_rd_valid ? mem_rdata_i[int'(r_rd_bank)*DataWidth +: DataWidth] : '0;

`ifdef SRAM_CTRL_BANKED_PERF_EN
  logic [31:0] r_rd_cnt, r_wr_cnt;
  logic        w_wr_fire;

  assign w_wr_fire = w_host_go & we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || w_init_start) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_fire && r_rd_cnt != 32'hFFFF_FFFF) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_wr_fire && r_wr_cnt != 32'hFFFF_FFFF) r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sram_ctrl_banked.sv
// Testbench for sram_ctrl_banked (NumBanks=2, Depth=4): directed vectors plus a per-cycle reference model.
module tb_sram_ctrl_banked;
  localparam int NB = 2;
  localparam int DP = 4;
  localparam int DW = 39;
  localparam int AW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i, init_req_i, escalate_i, req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          init_done_o, locked_o, gnt_o, rvalid_o, rerror_o;
  logic [DW-1:0] rdata_o;
  logic [NB-1:0] mem_req_o;
  logic          mem_we_o;
  logic [1:0]    mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [NB*DW-1:0] mem_rdata_i;
  logic [31:0]   rd_cnt_o, wr_cnt_o;

  int checks = 0;
  int fails  = 0;
  bit checkEn = 1'b0;

  always #5 clk_i = ~clk_i;

  sram_ctrl_banked #(.NumBanks(NB), .Depth(DP), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .init_req_i(init_req_i), .escalate_i(escalate_i),
    .init_done_o(init_done_o), .locked_o(locked_o), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .rerror_o(rerror_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o)
  );

  // Bank macros: single-port, one-cycle read latency.
  logic [DW-1:0] sram  [NB][DP];
  logic [DW-1:0] memRd [NB];
  always @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_req_o[b]) begin
        if (mem_we_o) sram[b][mem_addr_o] <= mem_wdata_o;
        else          memRd[b] <= sram[b][mem_addr_o];
      end
    end
  end
  assign mem_rdata_i = {memRd[1], memRd[0]};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // k-th word of the init pattern, obtained by stepping the Galois LFSR from the seed.
  function automatic logic [DW-1:0] lfsrAt(input int k);
    logic [31:0] l;
    l = 32'hACE1_1234;
    for (int i = 0; i < k; i++) l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    return DW'(l);
  endfunction

  // Reference model: phase 0 idle, 1 init, 2 ready, 3 locked; gold holds intended bank contents.
  int            mPhase = 0;
  int            mInitIdx = 0;
  logic          mRv = 1'b0, mRerr = 1'b0;
  logic [DW-1:0] mRdata = '0;
  logic [DW-1:0] gold [NB][DP];
  int            mRdCnt = 0, mWrCnt = 0;
  logic          cLock, cHost;
  logic [NB-1:0] cReq;

  always @(negedge clk_i) begin
    if (checkEn) begin
      cLock = (mPhase == 3) || escalate_i;
      cHost = !cLock && mPhase == 2 && !init_req_i && req_i;
      checkOutput("cmp_gnt", gnt_o, cLock ? req_i : cHost);
      if (cLock)            cReq = '0;
      else if (mPhase == 1) cReq = '1;
      else if (cHost)       cReq = NB'(1) << addr_i[2];
      else                  cReq = '0;
      checkOutput("cmp_mem_req", mem_req_o, cReq);
      if (!cLock && mPhase == 1) begin
        checkOutput("cmp_init_we", mem_we_o, 1'b1);
        checkOutput("cmp_init_addr", mem_addr_o, mInitIdx[1:0]);
        checkOutput("cmp_init_wdata", mem_wdata_o, lfsrAt(mInitIdx));
      end
      if (cHost) begin
        checkOutput("cmp_host_we", mem_we_o, we_i);
        checkOutput("cmp_host_addr", mem_addr_o, addr_i[1:0]);
        if (we_i) checkOutput("cmp_host_wdata", mem_wdata_o, wdata_i);
      end
      checkOutput("cmp_rvalid", rvalid_o, mRv);
      if (mRv) begin
        checkOutput("cmp_rerror", rerror_o, mRerr);
        checkOutput("cmp_rdata", rdata_o, mRdata);
      end
      checkOutput("cmp_init_done", init_done_o, mPhase == 2);
      checkOutput("cmp_locked", locked_o, mPhase == 3);
`ifdef SRAM_CTRL_BANKED_PERF_EN
      checkOutput("cmp_rd_cnt", rd_cnt_o, mRdCnt);
      checkOutput("cmp_wr_cnt", wr_cnt_o, mWrCnt);
`endif
      // advance the model by the edge that is about to sample these inputs
      mRv = 1'b0;
      if (rst_i) begin
        mPhase = 0; mInitIdx = 0; mRdCnt = 0; mWrCnt = 0;
      end else if (cLock) begin
        mPhase = 3;
        if (req_i && !we_i) begin mRv = 1'b1; mRerr = 1'b1; mRdata = '0; end
      end else if (mPhase == 0) begin
        if (init_req_i) begin mPhase = 1; mInitIdx = 0; mRdCnt = 0; mWrCnt = 0; end
      end else if (mPhase == 1) begin
        for (int b = 0; b < NB; b++) gold[b][mInitIdx] = lfsrAt(mInitIdx);
        mInitIdx++;
        if (mInitIdx == DP) begin mPhase = 2; mInitIdx = 0; end
      end else if (init_req_i) begin
        mPhase = 1; mInitIdx = 0; mRdCnt = 0; mWrCnt = 0;
      end else if (req_i) begin
        if (we_i) begin
          gold[addr_i[2]][addr_i[1:0]] = wdata_i;
          mWrCnt++;
        end else begin
          mRv = 1'b1; mRerr = 1'b0; mRdata = gold[addr_i[2]][addr_i[1:0]];
          mRdCnt++;
        end
      end
    end
  end

  // Records every all-bank write so init length and pattern can be inspected.
  logic [DW-1:0] initData [$];
  always @(negedge clk_i) begin
    if (mem_req_o == 2'b11 && mem_we_o) initData.push_back(mem_wdata_o);
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic initReq, input logic esc);
    req_i = req; we_i = we; addr_i = addr; wdata_i = wdata;
    init_req_i = initReq; escalate_i = esc;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (!init_done_o && n < 20) begin
      cycle();
      n++;
    end
  endtask

  int n;
  logic [AW-1:0] rdAddr [4];
  logic [DW-1:0] rdExp  [4];

  initial begin
    rdAddr = '{3'd0, 3'd4, 3'd5, 3'd1};
    rdExp  = '{39'h00_ACE1_1234, 39'h7F_0000_0001, 39'h12_3456_789A, 39'h00_5670_891A};
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, '0, 0, 0);
    cycle();
    checkEn = 1'b1;
    cycle();
    rst_i = 1'b0;
    checkOutput("reset_init_done", init_done_o, 1'b0);
    checkOutput("reset_locked", locked_o, 1'b0);
    checkOutput("reset_rvalid", rvalid_o, 1'b0);
    checkOutput("reset_mem_req", mem_req_o, 2'b00);
    checkOutput("model_lfsr3", lfsrAt(3), 39'h00_95BC_2245);

    applyStimulus(1, 0, 0, '0, 0, 0);
    #1 checkOutput("idle_gnt", gnt_o, 1'b0);
    cycle();

    // first initialisation
    initData.delete();
    applyStimulus(0, 0, 0, '0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, '0, 0, 0);
    waitDone(n);
    checkOutput("init_latency", n, 4);
    checkOutput("init_writes", initData.size(), 4);
    if (initData.size() == 4) begin
      checkOutput("init_word0", initData[0], 39'h00_ACE1_1234);
      checkOutput("init_word1", initData[1], 39'h00_5670_891A);
      checkOutput("init_word2", initData[2], 39'h00_2B38_448D);
      checkOutput("init_word3", initData[3], 39'h00_95BC_2245);
    end

    // host writes to bank1 words 1 and 0
    applyStimulus(1, 1, 5, 39'h12_3456_789A, 0, 0);
    #1 checkOutput("wr5_mem_req", mem_req_o, 2'b10);
    checkOutput("wr5_mem_addr", mem_addr_o, 2'd1);
    checkOutput("wr5_gnt", gnt_o, 1'b1);
    cycle();
    applyStimulus(1, 1, 4, 39'h7F_0000_0001, 0, 0);
    #1 checkOutput("wr4_mem_addr", mem_addr_o, 2'd0);
    cycle();
    applyStimulus(1, 0, 5, '0, 0, 0);
    checkOutput("wr_no_rvalid", rvalid_o, 1'b0);
    cycle();
    applyStimulus(0, 0, 0, '0, 0, 0);
    checkOutput("rd5_rvalid", rvalid_o, 1'b1);
    checkOutput("rd5_rdata", rdata_o, 39'h12_3456_789A);
    cycle();

    // back-to-back reads alternating banks
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, rdAddr[i], '0, 0, 0);
      cycle();
      checkOutput("b2b_rvalid", rvalid_o, 1'b1);
      checkOutput("b2b_rdata", rdata_o, rdExp[i]);
    end
    applyStimulus(0, 0, 0, '0, 0, 0);
    cycle();
    checkOutput("b2b_idle_rvalid", rvalid_o, 1'b0);

    // re-init from READY with a read still in flight, second request mid-INIT ignored
    applyStimulus(1, 0, 1, '0, 0, 0);
    cycle();
    applyStimulus(1, 0, 5, '0, 1, 0);
    #1 checkOutput("reinit_gnt", gnt_o, 1'b0);
    checkOutput("reinit_inflight_rvalid", rvalid_o, 1'b1);
    checkOutput("reinit_inflight_rdata", rdata_o, 39'h00_5670_891A);
    initData.delete();
    cycle();
    applyStimulus(0, 0, 0, '0, 0, 0);
    checkOutput("reinit_done_drop", init_done_o, 1'b0);
    checkOutput("reinit_no_rvalid", rvalid_o, 1'b0);
`ifdef SRAM_CTRL_BANKED_PERF_EN
    checkOutput("reinit_rd_clear", rd_cnt_o, 32'd0);
`endif
    cycle();
    cycle();
    applyStimulus(0, 0, 0, '0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, '0, 0, 0);
    waitDone(n);
    checkOutput("reinit_tail", n, 1);
    checkOutput("reinit_writes", initData.size(), 4);
    if (initData.size() > 0) checkOutput("reinit_seed", initData[0], 39'h00_ACE1_1234);

    // 2 writes + 3 reads
    applyStimulus(1, 1, 2, 39'h55_AAAA_5555, 0, 0);
    cycle();
    applyStimulus(1, 1, 7, 39'h01_0203_0405, 0, 0);
    cycle();
    applyStimulus(1, 0, 7, '0, 0, 0);
    cycle();
    applyStimulus(1, 0, 2, '0, 0, 0);
    checkOutput("perf_rd7", rdata_o, 39'h01_0203_0405);
    cycle();
    applyStimulus(1, 0, 3, '0, 0, 0);
    checkOutput("perf_rd2", rdata_o, 39'h55_AAAA_5555);
    cycle();
    applyStimulus(0, 0, 0, '0, 0, 0);
    checkOutput("perf_rd3", rdata_o, 39'h00_95BC_2245);
    cycle();
`ifdef SRAM_CTRL_BANKED_PERF_EN
    checkOutput("perf_rd_cnt", rd_cnt_o, 32'd3);
    checkOutput("perf_wr_cnt", wr_cnt_o, 32'd2);
`endif

    // re-init interrupted by reset
    applyStimulus(0, 0, 0, '0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, '0, 0, 0);
`ifdef SRAM_CTRL_BANKED_PERF_EN
    checkOutput("perf_rd_clear", rd_cnt_o, 32'd0);
    checkOutput("perf_wr_clear", wr_cnt_o, 32'd0);
`endif
    cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    checkOutput("midinit_rst_done", init_done_o, 1'b0);
    n = initData.size();
    cycle();
    cycle();
    checkOutput("midinit_rst_idle", initData.size(), n);

    initData.delete();
    applyStimulus(0, 0, 0, '0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, '0, 0, 0);
    waitDone(n);
    checkOutput("postrst_latency", n, 4);
    checkOutput("postrst_writes", initData.size(), 4);
    if (initData.size() > 0) checkOutput("postrst_seed", initData[0], 39'h00_ACE1_1234);

    // escalation with a read in flight and a read in the same cycle
    applyStimulus(1, 0, 1, '0, 0, 0);
    cycle();
    applyStimulus(1, 0, 5, '0, 0, 1);
    #1 checkOutput("esc_mem_req", mem_req_o, 2'b00);
    checkOutput("esc_gnt", gnt_o, 1'b1);
    checkOutput("esc_inflight_rdata", rdata_o, 39'h00_5670_891A);
    checkOutput("esc_inflight_rerror", rerror_o, 1'b0);
    cycle();
    applyStimulus(1, 1, 5, 39'h7E_DEAD_BEEF, 0, 0);
    #1 checkOutput("lock_locked", locked_o, 1'b1);
    checkOutput("lock_init_done", init_done_o, 1'b0);
    checkOutput("lock_rvalid", rvalid_o, 1'b1);
    checkOutput("lock_rerror", rerror_o, 1'b1);
    checkOutput("lock_rdata", rdata_o, 39'h0);
    checkOutput("lock_wr_gnt", gnt_o, 1'b1);
    checkOutput("lock_wr_mem_req", mem_req_o, 2'b00);
    cycle();
    applyStimulus(0, 0, 0, '0, 1, 0);
    checkOutput("lock_wr_no_rvalid", rvalid_o, 1'b0);
    cycle();
    applyStimulus(0, 0, 0, '0, 0, 0);
    cycle();
    checkOutput("lock_sticky", locked_o, 1'b1);
    checkOutput("lock_no_init", mem_req_o, 2'b00);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    checkOutput("lock_cleared", locked_o, 1'b0);
    cycle();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
